vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel-timing generator: sync, active qualifier and pixel coordinates
module vga_timing_gen #(
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   output logic        hor_sync,
   output logic        ver_sync,
   output logic        valid,
   output logic [10:0] hor_pos,
   output logic [10:0] ver_pos,
   output logic        line_start,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Region boundaries; the *_STOP values are exclusive upper bounds.
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT_STOP = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_STOP = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_STOP    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_STOP    = 11'(V_ACTIVE + V_FP + V_SYNC);

   // Counters are 11 bits wide, so neither total may exceed 2047.
   generate
      if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_too_large
         $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2047");
      end
   endgenerate

   logic [10:0] hor_pos_q, hor_pos_d;
   logic [10:0] ver_pos_q, ver_pos_d;
   logic        hor_sync_q, hor_sync_d;
   logic        ver_sync_q, ver_sync_d;
   logic        valid_q, valid_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic        h_act_d, v_act_d, h_sync_win_d, v_sync_win_d;

   // Next position, then every flag decoded from that next position so all
   // registered outputs describe the same pixel with no skew between them.
   always_comb begin
      hor_pos_d = hor_pos_q + 11'd1;
      ver_pos_d = ver_pos_q;
      if (hor_pos_q == H_LAST) begin
         hor_pos_d = 11'd0;
         ver_pos_d = (ver_pos_q == V_LAST) ? 11'd0 : ver_pos_q + 11'd1;
      end

      h_act_d       = (hor_pos_d < H_ACT_STOP);
      v_act_d       = (ver_pos_d < V_ACT_STOP);
      h_sync_win_d  = (hor_pos_d >= HS_START) && (hor_pos_d < HS_STOP);
      v_sync_win_d  = (ver_pos_d >= VS_START) && (ver_pos_d < VS_STOP);

      hor_sync_d    = h_sync_win_d ? H_SYNC_POL : ~H_SYNC_POL;
      ver_sync_d    = v_sync_win_d ? V_SYNC_POL : ~V_SYNC_POL;
      valid_d       = h_act_d & v_act_d;
      line_start_d  = (hor_pos_d == 11'd0);
      frame_start_d = (hor_pos_d == 11'd0) && (ver_pos_d == 11'd0);
   end

   // Output registers; reset parks on the last pixel of a frame so the first
   // enabled step lands on (0,0) without a dedicated start-up state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hor_pos_q     <= H_LAST;
         ver_pos_q     <= V_LAST;
         hor_sync_q    <= ~H_SYNC_POL;
         ver_sync_q    <= ~V_SYNC_POL;
         valid_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (ce) begin
         hor_pos_q     <= hor_pos_d;
         ver_pos_q     <= ver_pos_d;
         hor_sync_q    <= hor_sync_d;
         ver_sync_q    <= ver_sync_d;
         valid_q       <= valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hor_pos     = hor_pos_q;
   assign ver_pos     = ver_pos_q;
   assign hor_sync    = hor_sync_q;
   assign ver_sync    = ver_sync_q;
   assign valid       = valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n;
   logic ce_d, ce_w, ce_s;

   always #5 clk = ~clk;

   // default-timing instance
   logic d_hs, d_vs, d_val, d_ls, d_fs;
   logic [10:0] d_hp, d_vp;
   // SVGA-width override instance with positive hsync
   logic w_hs, w_vs, w_val, w_ls, w_fs;
   logic [10:0] w_hp, w_vp;
   // tiny raster so full frames fit in a short run: H 8/2/3/2 = 15, V 6/1/2/2 = 11
   logic s_hs, s_vs, s_val, s_ls, s_fs;
   logic [10:0] s_hp, s_vp;

   vga_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .ce(ce_d),
      .hor_sync(d_hs), .ver_sync(d_vs), .valid(d_val),
      .hor_pos(d_hp), .ver_pos(d_vp), .line_start(d_ls), .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88), .H_SYNC_POL(1'b1)
   ) u_wide (
      .clk(clk), .rst_n(rst_n), .ce(ce_w),
      .hor_sync(w_hs), .ver_sync(w_vs), .valid(w_val),
      .hor_pos(w_hp), .ver_pos(w_vp), .line_start(w_ls), .frame_start(w_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .ce(ce_s),
      .hor_sync(s_hs), .ver_sync(s_vs), .valid(s_val),
      .hor_pos(s_hp), .ver_pos(s_vp), .line_start(s_ls), .frame_start(s_fs)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference position for the small raster, following the step rule.
   int eh, ev;

   function automatic logic [26:0] small_exp(input int h, input int v);
      logic hs, vs, val, ls, fs;
      hs  = !(h >= 10 && h <= 12);
      vs  = !(v >= 7 && v <= 8);
      val = (h < 8) && (v < 6);
      ls  = (h == 0);
      fs  = (h == 0) && (v == 0);
      return {hs, vs, val, ls, fs, 11'(h), 11'(v)};
   endfunction

   task automatic small_adv();
      if (eh == 14) begin
         eh = 0;
         ev = (ev == 10) ? 0 : ev + 1;
      end else begin
         eh = eh + 1;
      end
   endtask

   function automatic logic [26:0] small_obs();
      return {s_hs, s_vs, s_val, s_ls, s_fs, s_hp, s_vp};
   endfunction

   int val_cnt, hs_cnt, hs_first, hs_last, pos_err, max_hp;
   int vs_cnt, fs_cnt, fs_t0, fs_t1, s_val_cnt;
   int found;

   initial begin
      rst_n = 1'b0;
      ce_d  = 1'b0;
      ce_w  = 1'b0;
      ce_s  = 1'b0;

      // ---- reset values ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_hpos", d_hp, 799);
      check_eq("rst_vpos", d_vp, 524);
      check_eq("rst_valid", d_val, 0);
      check_eq("rst_hsync", d_hs, 1);
      check_eq("rst_vsync", d_vs, 1);
      check_eq("rst_fstart", d_fs, 0);
      check_eq("rst_lstart", d_ls, 0);
      check_eq("rst_wide_hpos", w_hp, 1055);
      check_eq("rst_wide_hsync", w_hs, 0);
      check_eq("rst_small_pos", {s_hp, s_vp}, {11'd14, 11'd10});

      // ---- first step after release lands on (0,0) ----
      rst_n = 1'b1;
      ce_d  = 1'b1;
      step();
      check_eq("first_pos", {d_hp, d_vp}, 22'd0);
      check_eq("first_valid", d_val, 1);
      check_eq("first_fstart", d_fs, 1);
      check_eq("first_lstart", d_ls, 1);
      check_eq("first_syncs", {d_hs, d_vs}, 2'b11);

      // ---- horizontal timing over line 0 ----
      val_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; pos_err = 0;
      for (int i = 0; i < 800; i++) begin
         if (d_hp != 11'(i) || d_vp != 11'd0) pos_err++;
         if (d_val) val_cnt++;
         if (i == 639) check_eq("valid_at_639", d_val, 1);
         if (i == 640) check_eq("valid_at_640", d_val, 0);
         if (!d_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (i == 0) check_eq("line0_vsync", d_vs, 1);
         step();
      end
      check_eq("line0_pos_seq", pos_err, 0);
      check_eq("line0_valid_cnt", val_cnt, 640);
      check_eq("line0_hsync_cnt", hs_cnt, 96);
      check_eq("line0_hsync_first", hs_first, 656);
      check_eq("line0_hsync_last", hs_last, 751);
      check_eq("line1_pos", {d_hp, d_vp}, {11'd0, 11'd1});
      check_eq("line1_lstart", d_ls, 1);
      check_eq("line1_fstart", d_fs, 0);
      ce_d = 1'b0;

      // ---- parameter override: 1056-pixel line, active-high hsync ----
      ce_w = 1'b1;
      step();
      check_eq("wide_first_pos", {w_hp, w_vp}, 22'd0);
      hs_cnt = 0; hs_first = -1; hs_last = -1; max_hp = 0; val_cnt = 0;
      for (int i = 0; i < 1056; i++) begin
         if (int'(w_hp) > max_hp) max_hp = int'(w_hp);
         if (w_val) val_cnt++;
         if (w_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         step();
      end
      check_eq("wide_hsync_cnt", hs_cnt, 128);
      check_eq("wide_hsync_first", hs_first, 840);
      check_eq("wide_hsync_last", hs_last, 967);
      check_eq("wide_max_hpos", max_hp, 1055);
      check_eq("wide_valid_cnt", val_cnt, 800);
      check_eq("wide_wrap_pos", {w_hp, w_vp}, {11'd0, 11'd1});
      ce_w = 1'b0;

      // ---- small raster: two full frames, cycle-by-cycle ----
      eh = 14; ev = 10;
      ce_s = 1'b1;
      vs_cnt = 0; fs_cnt = 0; fs_t0 = -1; fs_t1 = -1; s_val_cnt = 0;
      for (int i = 0; i < 330; i++) begin
         step();
         small_adv();
         check_eq("small_frame", small_obs(), small_exp(eh, ev));
         if (!s_vs) vs_cnt++;
         if (s_val) s_val_cnt++;
         if (s_fs) begin
            fs_cnt++;
            if (fs_t0 < 0) fs_t0 = i; else if (fs_t1 < 0) fs_t1 = i;
         end
      end
      check_eq("small_vsync_cnt", vs_cnt, 60);
      check_eq("small_valid_cnt", s_val_cnt, 96);
      check_eq("small_fstart_cnt", fs_cnt, 2);
      check_eq("small_frame_period", fs_t1 - fs_t0, 165);

      // ---- clock enable at 1-in-4 ----
      fs_t0 = -1; fs_t1 = -1;
      for (int k = 0; k < 1400; k++) begin
         ce_s = (k % 4 == 0);
         @(posedge clk);
         if (ce_s) small_adv();
         @(negedge clk);
         check_eq("ce_div4", small_obs(), small_exp(eh, ev));
         if (s_fs && ce_s) begin
            if (fs_t0 < 0) fs_t0 = k; else if (fs_t1 < 0) fs_t1 = k;
         end
      end
      check_eq("ce_div4_frame_period", fs_t1 - fs_t0, 660);

      // ---- asynchronous reset at (11,7): inside both sync windows ----
      ce_s  = 1'b1;
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         step();
         if (s_hp == 11'd11 && s_vp == 11'd7) found = 1;
      end
      check_eq("arst_reach_target", found, 1);
      check_eq("arst_pre_syncs", {s_hs, s_vs}, 2'b00);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_pos", {s_hp, s_vp}, {11'd14, 11'd10});
      check_eq("arst_flags", {s_hs, s_vs, s_val, s_ls, s_fs}, 5'b11000);
      check_eq("arst_def_pos", {d_hp, d_vp}, {11'd799, 11'd524});
      @(negedge clk);
      check_eq("arst_held", {s_hp, s_vp}, {11'd14, 11'd10});
      rst_n = 1'b1;
      step();
      check_eq("arst_restart", {s_hp, s_vp, s_val, s_fs, s_ls}, {22'd0, 3'b111});
      step();
      check_eq("arst_next", {s_hp, s_vp, s_fs, s_ls}, {11'd1, 11'd0, 2'b00});
      ce_s = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
